alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous discard of the pending response.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 reqN_ctrl  input  4  ALU operation code, passed through unmodified.
REQ-008 reqN_src1, reqN_src2  input  WIDTH  ALU operands 1 and 2.
REQ-009 respN_valid  output  1  result for requester N is held.
REQ-010 respN_ready  input  1  requester N consumes the result.
REQ-011 resp_result  output  WIDTH  registered ALU result, shared by both response ports.
REQ-012 resp_flags  output  3  registered {carry, zero, overflow}.
REQ-013 alu_ctrl  output  4; alu_in1, alu_in2  output  WIDTH  combinational drive to the shared ALU.
REQ-014 alu_result  input  WIDTH; alu_carry, alu_zero, alu_overflow  input  1  combinational ALU return.

Function
REQ-015 The FSM SHALL have two states: IDLE (no response held) and RESP (response held for owner O).
REQ-016 A grant SHALL be possible when state is IDLE, or RESP with respO_valid && respO_ready in the same cycle.
REQ-017 When a grant is possible and exactly one reqN_valid is high, requester N SHALL be granted.
REQ-018 When both are valid, the requester equal to round-robin pointer P SHALL be granted.
REQ-019 After every grant to N, P SHALL become 1-N; P SHALL NOT change without a grant.
REQ-020 reqN_ready SHALL be high only for the granted requester, combinationally from valids, state, P and resp handshake; at most one ready high per cycle.
REQ-021 During a grant, alu_ctrl/alu_in1/alu_in2 SHALL equal the granted requester's ctrl/src1/src2; otherwise they SHALL be all zeros.
REQ-022 On the granting edge, alu_result and {alu_carry, alu_zero, alu_overflow} SHALL be captured into resp_result/resp_flags, O set to N, state to RESP.
REQ-023 Latency SHALL be 1 cycle: respO_valid high the cycle after acceptance; sustained throughput one operation per cycle under continuous consumption.
REQ-024 respN_valid SHALL be high only in RESP with N==O; resp_result/resp_flags SHALL remain stable while valid and not consumed.
REQ-025 Response handshake without a new grant SHALL return the FSM to IDLE; with a new grant it SHALL stay in RESP with new data and owner.
REQ-026 flush high SHALL suppress all grants that cycle (both readies low) and force IDLE next cycle; P unchanged.
REQ-027 flush SHALL take priority over a simultaneous response handshake; the response is considered dropped.
REQ-028 reqN_valid deasserting without ready SHALL be legal; no state change results.
REQ-029 The arbiter SHALL NOT interpret ctrl; all 16 codes are forwarded identically.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, P=0, O=0, resp_result=0, resp_flags=0, all respN_valid=0, all reqN_ready=0.
REQ-031 Reset asserted mid-operation SHALL discard any held response without handshake.
REQ-032 The first grant after reset release SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-033 FSM state encoding and the 4-bit ALU ctrl code constants SHALL live in a shared package used by the ALU decoder and this block.
REQ-034 Grant selection (valids, P, grant-possible -> one-hot grant) SHALL be a sub-module rr_arbiter2; the ALU itself SHALL remain external.

Verification
REQ-035 Single request: req0 ctrl=add, src1=5, src2=7 -> req0_ready same cycle, next cycle resp0_valid=1, resp_result=12.
REQ-036 Contention: both valid every cycle after reset -> grants alternate 0,1,0,1; P toggles each grant.
REQ-037 Backpressure: resp1_ready low 3 cycles -> both readies low, resp_result stable, grant on cycle respO_ready rises.
REQ-038 Back-to-back: req0 continuous valid, resp0_ready always 1 -> one result per cycle, state stays RESP.
REQ-039 Flush: flush with resp0_valid=1 and resp0_ready=1 -> no grant that cycle, IDLE next, resp0_valid=0, P unchanged.
REQ-040 Async reset mid-RESP: rst_n low between edges -> respN_valid=0 and resp_result=0 before next edge; P=0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and the external ALU decoder:
// FSM state encoding, ALU operation codes and grant constants.
package alu_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

  // ALU operation codes; the arbiter never decodes them, only the ALU does.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;

  localparam logic [1:0] GRANT_NONE = 2'b00;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant selection: one-hot grant from the valids, the
// round-robin pointer and a grant-possible enable.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant_o = GRANT_NONE;
    if (en_i) begin
      if (&valid_i) begin
        grant_o = ptr_i ? 2'b10 : 2'b01;
      end else begin
        grant_o = valid_i;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with round-robin
// arbitration and a single registered response slot tagged with its owner.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctrl,
  input  logic [WIDTH-1:0] req0_src1,
  input  logic [WIDTH-1:0] req0_src2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctrl,
  input  logic [WIDTH-1:0] req1_src1,
  input  logic [WIDTH-1:0] req1_src2,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [2:0]       resp_flags,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow
);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [2:0]       flags_q, flags_d;

  logic       handshake;
  logic       grant_en;
  logic [1:0] grant;

  assign resp0_valid = (state_q == ST_RESP) && !owner_q;
  assign resp1_valid = (state_q == ST_RESP) &&  owner_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;

  assign handshake = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

  // rst_n gates the enable so no ready can rise while reset is held.
  assign grant_en = rst_n && !flush && ((state_q == ST_IDLE) || handshake);

  rr_arbiter2 u_rr_arbiter2 (
    .valid_i ({req1_valid, req0_valid}),
    .ptr_i   (ptr_q),
    .en_i    (grant_en),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_ctrl = '0;
    alu_in1  = '0;
    alu_in2  = '0;
    if (grant[0]) begin
      alu_ctrl = req0_ctrl;
      alu_in1  = req0_src1;
      alu_in2  = req0_src2;
    end else if (grant[1]) begin
      alu_ctrl = req1_ctrl;
      alu_in1  = req1_src1;
      alu_in2  = req1_src2;
    end
  end

  // Flush outranks everything, including a response consumed in the same cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else if (grant != GRANT_NONE) begin
      state_d  = ST_RESP;
      owner_d  = grant[1];
      ptr_d    = ~grant[1];
      result_d = alu_result;
      flags_d  = {alu_carry, alu_zero, alu_overflow};
    end else if (handshake) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: the bench plays the external ALU and keeps a
// reference arbitration model that pushes expected responses into a scoreboard.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_ctrl = '0, req1_ctrl = '0;
  logic [W-1:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
  logic         resp0_valid, resp1_valid;
  logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [W-1:0] resp_result;
  logic [2:0]   resp_flags;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_in1, alu_in2, alu_result;
  logic         alu_carry, alu_zero, alu_overflow;

  typedef struct packed {
    logic         owner;
    logic [W-1:0] result;
    logic [2:0]   flags;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       m_ptr = 1'b0, m_busy = 1'b0, m_owner = 1'b0;
  logic [1:0] exp_grant = 2'b00;
  logic [3:0] exp_ctrl = '0;
  logic [W-1:0] exp_in1 = '0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow)
  );

  // Reference ALU, returns {carry, zero, overflow, result}.
  function automatic logic [W+2:0] alu_model(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         cy, ov;
    s = '0; cy = 1'b0; ov = 1'b0;
    case (c)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; cy = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; cy = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {{(W-1){1'b0}}, (a < b)};
      default:  r = a ^ {{(W-4){1'b0}}, c};
    endcase
    return {cy, (r == '0), ov, r};
  endfunction

  assign {alu_carry, alu_zero, alu_overflow, alu_result} = alu_model(alu_ctrl, alu_in1, alu_in2);

  function automatic logic [1:0] exp_rv();
    if (exp_q.size() == 0) return 2'b00;
    return exp_q[0].owner ? 2'b10 : 2'b01;
  endfunction

  // Drives one cycle of stimulus and advances the reference model and scoreboard.
  task automatic drive(input logic v0, input logic [3:0] c0, input logic [W-1:0] a0,
                       input logic [W-1:0] b0, input logic v1, input logic [3:0] c1,
                       input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input logic rr0, input logic rr1, input logic fl);
    logic possible, owner_rdy, n;
    exp_t e;
    req0_valid = v0; req0_ctrl = c0; req0_src1 = a0; req0_src2 = b0;
    req1_valid = v1; req1_ctrl = c1; req1_src1 = a1; req1_src2 = b1;
    resp0_ready = rr0; resp1_ready = rr1; flush = fl;
    owner_rdy = m_owner ? rr1 : rr0;
    possible  = !fl && (!m_busy || owner_rdy);
    exp_grant = 2'b00;
    if (possible) exp_grant = (v0 && v1) ? (m_ptr ? 2'b10 : 2'b01) : {v1, v0};
    exp_ctrl = exp_grant[0] ? c0 : (exp_grant[1] ? c1 : 4'h0);
    exp_in1  = exp_grant[0] ? a0 : (exp_grant[1] ? a1 : '0);
    if (m_busy && (fl || owner_rdy)) begin
      void'(exp_q.pop_front());
      m_busy = 1'b0;
    end
    if (exp_grant != 2'b00) begin
      n = exp_grant[1];
      e.owner = n;
      {e.flags, e.result} = alu_model(n ? c1 : c0, n ? a1 : a0, n ? b1 : b0);
      exp_q.push_back(e);
      m_busy = 1'b1; m_owner = n; m_ptr = !n;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.delete();
    m_ptr = 1'b0; m_busy = 1'b0; m_owner = 1'b0; exp_grant = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_ctrl = ALU_ADD; req0_src1 = 32'd9;
    #2;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
    end
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_resp_valid: got %b want 00", {resp1_valid, resp0_valid});
    end
    checks++;
    if (resp_result !== '0 || resp_flags !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_result: got %h/%b want 0/000", resp_result, resp_flags);
    end
    checks++;
    if (alu_ctrl !== 4'h0 || alu_in1 !== '0 || alu_in2 !== '0) begin
      errors++; $display("[TB] FAIL reset_alu_drive: got %h %h %h want zeros", alu_ctrl, alu_in1, alu_in2);
    end
    apply_reset();
  endtask

  task automatic test_single();
    drive(1, ALU_ADD, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL single_ready: got %b want 01", {req1_ready, req0_ready});
    end
    checks++;
    if (alu_ctrl !== ALU_ADD || alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin
      errors++; $display("[TB] FAIL single_alu_drive: got %h %0d %0d want 0 5 7", alu_ctrl, alu_in1, alu_in2);
    end
    @(posedge clk); #1;
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b01 || resp_result !== 32'd12) begin
      errors++; $display("[TB] FAIL single_resp: got v=%b r=%0d want v=01 r=12", {resp1_valid, resp0_valid}, resp_result);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL single_consume: got %b want 00", {resp1_valid, resp0_valid});
    end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, ALU_ADD, W'(i), 32'd10, 1, ALU_SUB, 32'd100, W'(i), 1, 1, 0);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("[TB] FAIL contention_grant[%0d]: got %b want %b", i,
                           {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1;
      checks++;
      if ({resp1_valid, resp0_valid} !== exp_rv() || resp_result !== exp_q[0].result
          || resp_flags !== exp_q[0].flags) begin
        errors++; $display("[TB] FAIL contention_resp[%0d]: got v=%b r=%h f=%b want v=%b r=%h f=%b", i,
                           {resp1_valid, resp0_valid}, resp_result, resp_flags,
                           exp_rv(), exp_q[0].result, exp_q[0].flags);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    drive(0, 0, 0, 0, 1, ALU_ADD, 32'd3, 32'd4, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1, ALU_OR, 32'hF0, 32'h0F, 1, ALU_AND, 32'hFF, 32'h3C, 1, 0, 0);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        errors++; $display("[TB] FAIL backpressure_ready[%0d]: got %b want 00", i, {req1_ready, req0_ready});
      end
      @(posedge clk); #1;
      checks++;
      if (resp1_valid !== 1'b1 || resp_result !== 32'd7) begin
        errors++; $display("[TB] FAIL backpressure_hold[%0d]: got v1=%b r=%0d want v1=1 r=7", i, resp1_valid, resp_result);
      end
    end
    drive(1, ALU_OR, 32'hF0, 32'h0F, 1, ALU_AND, 32'hFF, 32'h3C, 1, 1, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01 || {req1_ready, req0_ready} !== exp_grant) begin
      errors++; $display("[TB] FAIL backpressure_release: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b01 || resp_result !== 32'hFF) begin
      errors++; $display("[TB] FAIL backpressure_next: got v=%b r=%h want v=01 r=ff", {resp1_valid, resp0_valid}, resp_result);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 16; c++) begin
      drive(1, 4'(c), $urandom, $urandom, 0, 0, 0, 0, 1, 0, 0);
      #1;
      checks++;
      if (req0_ready !== 1'b1 || alu_ctrl !== 4'(c) || alu_in1 !== exp_in1) begin
        errors++; $display("[TB] FAIL b2b_accept[%0d]: got rdy=%b ctrl=%h in1=%h want 1 %h %h", c,
                           req0_ready, alu_ctrl, alu_in1, exp_ctrl, exp_in1);
      end
      @(posedge clk); #1;
      checks++;
      if (resp0_valid !== 1'b1 || resp_result !== exp_q[0].result || resp_flags !== exp_q[0].flags) begin
        errors++; $display("[TB] FAIL b2b_resp[%0d]: got v=%b r=%h f=%b want v=1 r=%h f=%b", c,
                           resp0_valid, resp_result, resp_flags, exp_q[0].result, exp_q[0].flags);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL b2b_drain: got %b want 00", {resp1_valid, resp0_valid});
    end
  endtask

  task automatic test_flush();
    drive(1, ALU_XOR, 32'hA5A5, 32'h5A5A, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, ALU_ADD, 32'd1, 32'd1, 1, ALU_ADD, 32'd2, 32'd2, 1, 1, 1);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00 || alu_ctrl !== 4'h0 || alu_in1 !== '0) begin
      errors++; $display("[TB] FAIL flush_grant: got rdy=%b ctrl=%h in1=%h want 00 0 0",
                         {req1_ready, req0_ready}, alu_ctrl, alu_in1);
    end
    @(posedge clk); #1;
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b00) begin
      errors++; $display("[TB] FAIL flush_idle: got %b want 00", {resp1_valid, resp0_valid});
    end
    drive(1, ALU_ADD, 32'd1, 32'd1, 1, ALU_ADD, 32'd2, 32'd2, 0, 0, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL flush_ptr: got %b want 10", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b10 || resp_result !== 32'd4) begin
      errors++; $display("[TB] FAIL flush_after: got v=%b r=%0d want v=10 r=4", {resp1_valid, resp0_valid}, resp_result);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    drive(1, ALU_SUB, 32'd50, 32'd8, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({resp1_valid, resp0_valid} !== 2'b00 || resp_result !== '0 || resp_flags !== 3'b000) begin
      errors++; $display("[TB] FAIL async_reset: got v=%b r=%h f=%b want 00 0 000",
                         {resp1_valid, resp0_valid}, resp_result, resp_flags);
    end
    exp_q.delete();
    m_ptr = 1'b0; m_busy = 1'b0; m_owner = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1, 1, 0);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL async_reset_ptr: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    checks++;
    if (resp0_valid !== 1'b1 || resp_result !== 32'd1) begin
      errors++; $display("[TB] FAIL async_reset_resp: got v0=%b r=%0d want v0=1 r=1", resp0_valid, resp_result);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
